packet_rx: RTL
==============

PACKET_RX -- requirements
Module: packet_rx

Interface
REQ-001 The module SHALL have a parameter RESOLUTION, default 24: payload word width in bits; it must be a multiple of 4.
REQ-002 The module SHALL have a parameter NUM_WORDS, default 80: number of payload words per packet.
REQ-003 The module SHALL have a parameter NUM_INPUTS, default 8: expected input count, used only by the header check.
REQ-004 The module SHALL have a port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The module SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have a port rx_data, input, 8 bits: received byte, as delivered by uart_rx.
REQ-007 The module SHALL have a port rx_valid, input, 1 bit: one-cycle strobe marking rx_data as valid.
REQ-008 The module SHALL have a port word_data, output, RESOLUTION bits: decoded payload word.
REQ-009 The module SHALL have a port word_valid, output, 1 bit: one-cycle strobe marking word_data and word_index as valid.
REQ-010 The module SHALL have a port word_index, output, 16 bits: payload word number, starting at 0 from the first word after the header.
REQ-011 The module SHALL have a port hdr_tick, output, 16 bits: header TICK field.
REQ-012 The module SHALL have a port hdr_flags, output, 4 bits: header feature flags (bit0 crosscorrelator, bit1 leds, bit2 psu, bit3 cumulative-only).
REQ-013 The module SHALL have a port hdr_lag_cross, output, 8 bits: LAG_CROSS-1.
REQ-014 The module SHALL have a port hdr_lag_auto, output, 8 bits: LAG_AUTO-1.
REQ-015 The module SHALL have a port hdr_delay, output, 12 bits: DELAY_SIZE.
REQ-016 The module SHALL have a port hdr_inputs, output, 8 bits: NUM_INPUTS-1.
REQ-017 The module SHALL have a port hdr_resolution, output, 8 bits: RESOLUTION.
REQ-018 The module SHALL have a port timestamp, output, 64 bits: footer timestamp of the last good packet.
REQ-019 The module SHALL have a port packet_done, output, 1 bit: one-cycle strobe marking a good packet.
REQ-020 The module SHALL have a port packet_error, output, 1 bit: one-cycle strobe marking a malformed packet.

Function
REQ-021 Packet format SHALL be ASCII hex nibbles, MSB nibble first, in order: header (16 nibbles), NUM_WORDS*RESOLUTION/4 payload nibbles, footer (16 nibbles), then one 0x0D terminator.
REQ-022 Accepted nibble characters SHALL be 0x30-0x39, 0x41-0x46 and 0x61-0x66; any other byte except 0x0D SHALL be illegal.
REQ-023 The header SHALL be decoded MSB-first as [63:56] resolution, [55:48] inputs, [47:36] delay, [35:28] lag_auto, [27:20] lag_cross, [19:16] flags, [15:0] tick.
REQ-024 The FSM SHALL have states SYNC, HEADER, PAYLOAD, FOOTER and TERM.
REQ-025 SYNC SHALL discard every byte until 0x0D, then go to HEADER.
REQ-026 HEADER SHALL shift in 16 nibbles, go to PAYLOAD, and load the hdr_* outputs one cycle after the 16th nibble.
REQ-027 PAYLOAD SHALL assemble RESOLUTION/4 nibbles per word and pulse word_valid on the cycle after each word's last nibble, with word_index incrementing from 0 to NUM_WORDS-1.
REQ-028 After the last payload word, the FSM SHALL go to FOOTER, which shifts in 16 nibbles into a holding register, then go to TERM.
REQ-029 In TERM, byte 0x0D SHALL copy the holding register to timestamp, pulse packet_done one cycle later, and go to HEADER.
REQ-030 In TERM, any other byte SHALL pulse packet_error and go to SYNC.
REQ-031 An illegal byte in HEADER, PAYLOAD or FOOTER SHALL pulse packet_error and go to SYNC.
REQ-032 Byte 0x0D in HEADER, PAYLOAD or FOOTER (early terminator) SHALL pulse packet_error and go to HEADER, which resynchronises immediately.
REQ-033 Words already emitted before an error SHALL NOT be retracted; timestamp SHALL update only on packet_done.
REQ-034 Cycles with rx_valid low SHALL hold all state; gaps of any length between bytes SHALL be tolerated.
REQ-035 The nibble counter SHALL be 16 bits wide, and word_index SHALL NOT wrap within a packet.

Reset
REQ-036 Reset SHALL force state SYNC, clear all counters, and drive every output to 0.
REQ-037 Reset asserted mid-packet SHALL abort the packet with no packet_error strobe and no word_valid strobe.
REQ-038 Reset SHALL take priority over rx_valid in the same cycle.

Configuration
REQ-039 The header check SHALL be compiled in when macro PACKET_RX_HDR_CHECK_EN is defined.
REQ-040 With the macro defined: if hdr_resolution != RESOLUTION or hdr_inputs != NUM_INPUTS-1 after the header, the block SHALL pulse packet_error, emit no words, and go to SYNC.
REQ-041 Without the macro, header fields SHALL be reported only, with no check.

Verification
REQ-042 Reset, 0x0D, a header with resolution 0x18 and inputs 0x07, 80 words where word n = n, footer 0x0000000000001234, 0x0D -> 80 word_valid with word_index 0..79 and data 0..79, timestamp=0x1234, one packet_done.
REQ-043 Lowercase hex "00000a" as word 0 -> word_data=0x00000A.
REQ-044 Byte 0x47 ('G') at payload word 5 -> words 0-4 emitted, packet_error, no further words until the next 0x0D plus a good packet.
REQ-045 0x0D after 10 payload words -> packet_error, and a following complete packet decodes correctly with no leading 0x0D.
REQ-046 Reset asserted at payload word 40 -> all outputs 0, no strobes, and the next packet is ignored until a 0x0D is seen.
REQ-047 With PACKET_RX_HDR_CHECK_EN defined, a header with resolution 0x10 -> packet_error and zero word_valid; without the macro -> 80 words emitted.

Source files
------------

// File: rtl/packet_rx.sv
// ASCII-hex packet receiver: header, payload words, footer timestamp.
// Optional header check: define PACKET_RX_HDR_CHECK_EN.
module packet_rx #(
  parameter int RESOLUTION = 24,
  parameter int NUM_WORDS  = 80,
  parameter int NUM_INPUTS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [RESOLUTION-1:0] word_data,
  output logic                  word_valid,
  output logic [15:0]           word_index,
  output logic [15:0]           hdr_tick,
  output logic [3:0]            hdr_flags,
  output logic [7:0]            hdr_lag_cross,
  output logic [7:0]            hdr_lag_auto,
  output logic [11:0]           hdr_delay,
  output logic [7:0]            hdr_inputs,
  output logic [7:0]            hdr_resolution,
  output logic [63:0]           timestamp,
  output logic                  packet_done,
  output logic                  packet_error
);

  localparam int NPW = RESOLUTION / 4;
  localparam logic [7:0] CR = 8'h0D;

  localparam logic [2:0] S_SYNC    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_FOOTER  = 3'd3;
  localparam logic [2:0] S_TERM    = 3'd4;

`ifdef PACKET_RX_HDR_CHECK_EN
  localparam bit HDR_CHK = 1'b1;
`else
  localparam bit HDR_CHK = 1'b0;
`endif

  logic [2:0]            state;
  logic [15:0]           nib_cnt;
  logic [15:0]           word_cnt;
  logic [63:0]           hdr_sr;
  logic [63:0]           foot_sr;
  logic [RESOLUTION-1:0] word_sr;

  logic                  is_hex;
  logic                  is_cr;
  logic [3:0]            nib;
  logic [63:0]           hdr_next;
  logic [63:0]           foot_next;
  logic [RESOLUTION+3:0] word_tmp;
  logic [RESOLUTION-1:0] word_next;
  logic                  hdr_bad;

  // Classify the incoming byte and form the shifted-in values.
  always_comb begin
    is_hex = 1'b0;
    nib    = 4'd0;
    unique case (1'b1)
      (rx_data >= 8'h30 && rx_data <= 8'h39): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0];
      end
      (rx_data >= 8'h41 && rx_data <= 8'h46),
      (rx_data >= 8'h61 && rx_data <= 8'h66): begin
        is_hex = 1'b1;
        nib    = rx_data[3:0] + 4'd9;
      end
      default: ;
    endcase
    is_cr     = (rx_data == CR);
    hdr_next  = {hdr_sr[59:0], nib};
    foot_next = {foot_sr[59:0], nib};
    word_tmp  = {word_sr, nib};
    word_next = word_tmp[RESOLUTION-1:0];
    hdr_bad   = HDR_CHK &&
                ((hdr_next[63:56] != 8'(RESOLUTION)) ||
                 (hdr_next[55:48] != 8'(NUM_INPUTS - 1)));
  end

  // Packet FSM, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_SYNC;
      nib_cnt        <= '0;
      word_cnt       <= '0;
      hdr_sr         <= '0;
      foot_sr        <= '0;
      word_sr        <= '0;
      word_data      <= '0;
      word_valid     <= 1'b0;
      word_index     <= '0;
      hdr_tick       <= '0;
      hdr_flags      <= '0;
      hdr_lag_cross  <= '0;
      hdr_lag_auto   <= '0;
      hdr_delay      <= '0;
      hdr_inputs     <= '0;
      hdr_resolution <= '0;
      timestamp      <= '0;
      packet_done    <= 1'b0;
      packet_error   <= 1'b0;
    end else begin
      word_valid   <= 1'b0;
      packet_done  <= 1'b0;
      packet_error <= 1'b0;
      if (rx_valid) begin
        if (state == S_SYNC) begin
          if (is_cr) begin
            state   <= S_HEADER;
            nib_cnt <= '0;
          end
        end else if (state == S_TERM) begin
          nib_cnt  <= '0;
          word_cnt <= '0;
          if (is_cr) begin
            timestamp   <= foot_sr;
            packet_done <= 1'b1;
            state       <= S_HEADER;
          end else begin
            packet_error <= 1'b1;
            state        <= S_SYNC;
          end
        end else if (!is_hex) begin
          // Early CR resyncs straight into a new header.
          packet_error <= 1'b1;
          nib_cnt      <= '0;
          word_cnt     <= '0;
          state        <= is_cr ? S_HEADER : S_SYNC;
        end else begin
          unique case (state)
            S_HEADER: begin
              hdr_sr <= hdr_next;
              if (nib_cnt == 16'd15) begin
                hdr_resolution <= hdr_next[63:56];
                hdr_inputs     <= hdr_next[55:48];
                hdr_delay      <= hdr_next[47:36];
                hdr_lag_auto   <= hdr_next[35:28];
                hdr_lag_cross  <= hdr_next[27:20];
                hdr_flags      <= hdr_next[19:16];
                hdr_tick       <= hdr_next[15:0];
                nib_cnt        <= '0;
                word_cnt       <= '0;
                if (hdr_bad) begin
                  packet_error <= 1'b1;
                  state        <= S_SYNC;
                end else if (NUM_WORDS == 0) begin
                  state <= S_FOOTER;
                end else begin
                  state <= S_PAYLOAD;
                end
              end else begin
                nib_cnt <= nib_cnt + 16'd1;
              end
            end
            S_PAYLOAD: begin
              word_sr <= word_next;
              if (nib_cnt == 16'(NPW - 1)) begin
                word_data  <= word_next;
                word_valid <= 1'b1;
                word_index <= word_cnt;
                nib_cnt    <= '0;
                if (word_cnt == 16'(NUM_WORDS - 1)) begin
                  state <= S_FOOTER;
                end else begin
                  word_cnt <= word_cnt + 16'd1;
                end
              end else begin
                nib_cnt <= nib_cnt + 16'd1;
              end
            end
            S_FOOTER: begin
              foot_sr <= foot_next;
              if (nib_cnt == 16'd15) begin
                nib_cnt <= '0;
                state   <= S_TERM;
              end else begin
                nib_cnt <= nib_cnt + 16'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
